// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, derived totals/sync windows and widths.
package vga_pkg;
    localparam int CLK_DIV   = 4;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int CNT_W = 10;
    localparam int COL_W = 7;
    localparam int ROW_W = 5;
endpackage

// File: rtl/vga_sync_font_pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock into a registered one-cycle pixel enable.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Free-running divider; tick is high for the cycle after the last count.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= div_cnt == DIV_LAST;
        end
endmodule

// File: rtl/vga_sync_font.sv
// vga_sync_font: VGA timing counters, font ROM addressing and pixel-aligned output stage.
module vga_sync_font
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       FONT_BYTE,
    output logic [COL_W-1:0] CHAR_COL,
    output logic [ROW_W-1:0] CHAR_ROW,
    output logic [3:0]       FONT_ROW,
    output logic             PIXEL_TICK,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             H_ON,
    output logic             V_ON,
    output logic             BIT_FUENTE,
    output logic [CNT_W-1:0] PIXEL_X,
    output logic [CNT_W-1:0] PIXEL_Y
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic h_wrap, v_wrap, h_vis, v_vis;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (CLK),
        .rst_n(RESET),
        .tick (PIXEL_TICK)
    );

    assign h_wrap   = h_cnt == H_LAST;
    assign v_wrap   = v_cnt == V_LAST;
    assign h_vis    = h_cnt < H_VIS;
    assign v_vis    = v_cnt < V_VIS;
    assign CHAR_COL = h_cnt[9:3];
    assign CHAR_ROW = v_cnt[8:4];
    assign FONT_ROW = v_cnt[3:0];

    // Raster position; the line counter steps only when the pixel counter wraps.
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (PIXEL_TICK) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end

    // Output stage registers the decode of the pre-advance position, one pixel behind the addresses.
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            HSYNC      <= 1'b1;
            VSYNC      <= 1'b1;
            H_ON       <= 1'b0;
            V_ON       <= 1'b0;
            BIT_FUENTE <= 1'b0;
            PIXEL_X    <= '0;
            PIXEL_Y    <= '0;
        end else if (PIXEL_TICK) begin
            HSYNC      <= !(h_cnt >= HS_START && h_cnt <= HS_END);
            VSYNC      <= !(v_cnt >= VS_START && v_cnt <= VS_END);
            H_ON       <= h_vis;
            V_ON       <= v_vis;
            BIT_FUENTE <= h_vis && v_vis && FONT_BYTE[3'd7 - h_cnt[2:0]];
            PIXEL_X    <= h_cnt;
            PIXEL_Y    <= v_cnt;
        end
endmodule
